pcie_flr_sequencer: RTL

Sits directly downstream of the PCIe subsystem's FLR request output and feeds its FLR response input. Captures function-level reset requests (PF or VF) into a small queue, then processes them one at a time:
- drives a per-function reset toward the AFU/port logic,
- holds it for a minimum interval,
- waits for the port to acknowledge quiesce,
- returns the matching FLR completion to the subsystem.

---
 rtl/pcie_flr_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pcie_flr_sequencer.sv
// FLR sequencer: queues PF/VF function-level resets and runs them one at a time.
// Optional WAIT_ACK timeout is built when FLR_TIMEOUT_EN is defined.
module pcie_flr_sequencer #(
  parameter int FIFO_DEPTH      = 8,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                          fim_clk,
  input  logic                          fim_rst,
  input  logic                          flr_req_tvalid,
  input  logic [2:0]                    flr_req_pf,
  input  logic [10:0]                   flr_req_vf,
  input  logic                          flr_req_vf_active,
  output logic                          flr_rsp_tvalid,
  output logic [2:0]                    flr_rsp_pf,
  output logic [10:0]                   flr_rsp_vf,
  output logic                          flr_rsp_vf_active,
  output logic                          func_rst_valid,
  output logic [2:0]                    func_rst_pf,
  output logic [10:0]                   func_rst_vf,
  output logic                          func_rst_vf_active,
  input  logic                          func_rst_ack,
  output logic                          overflow_err,
  output logic                          timeout_err,
  output logic [$clog2(FIFO_DEPTH):0]   pending_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ASSERT, S_WAIT_ACK, S_RESP
  } state_t;

  state_t r_state, w_state_nxt;

  logic [14:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic [HW-1:0] r_hold;
  logic [14:0]   r_act_id, r_rsp_id;
  logic          r_rst_valid, r_rsp_valid, r_ovf;
  logic          w_empty, w_full, w_pop, w_push;
  logic          w_rst_valid, w_rsp_valid;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == FULL_CNT);
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  // a pop in the same cycle frees the slot, so a full queue still accepts
  assign w_push  = flr_req_tvalid && (!w_full || w_pop);

`ifdef FLR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_to_err, w_to_err;

  always_ff @(posedge fim_clk) begin
    if (fim_rst) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_err <= w_to_err;
      if (r_state == S_WAIT_ACK) r_to_cnt <= r_to_cnt + 1'b1;
      else                       r_to_cnt <= '0;
    end
  end

  assign timeout_err = r_to_err;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES > 0);
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_rst_valid = r_rst_valid;
    w_rsp_valid = 1'b0;
`ifdef FLR_TIMEOUT_EN
    w_to_err    = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_ASSERT;
          w_rst_valid = 1'b1;
        end
      end
      S_ASSERT: begin
        if (r_hold == HOLD_LAST) w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (func_rst_ack) begin
          w_state_nxt = S_RESP;
          w_rst_valid = 1'b0;
          w_rsp_valid = 1'b1;
        end
`ifdef FLR_TIMEOUT_EN
        else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = S_RESP;
          w_rst_valid = 1'b0;
          w_rsp_valid = 1'b1;
          w_to_err    = 1'b1;
        end
`endif
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge fim_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {flr_req_pf, flr_req_vf, flr_req_vf_active};
  end

  always_ff @(posedge fim_clk) begin
    if (fim_rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_act_id    <= '0;
      r_rsp_id    <= '0;
      r_rst_valid <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rst_valid <= w_rst_valid;
      r_rsp_valid <= w_rsp_valid;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_act_id <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      if (flr_req_tvalid && !w_push) r_ovf <= 1'b1;
      if (r_state == S_ASSERT) r_hold <= r_hold + 1'b1;
      else                     r_hold <= '0;
      if (w_rsp_valid) r_rsp_id <= r_act_id;
    end
  end

  assign flr_rsp_tvalid     = r_rsp_valid;
  assign flr_rsp_pf         = r_rsp_id[14:12];
  assign flr_rsp_vf         = r_rsp_id[11:1];
  assign flr_rsp_vf_active  = r_rsp_id[0];
  assign func_rst_valid     = r_rst_valid;
  assign func_rst_pf        = r_act_id[14:12];
  assign func_rst_vf        = r_act_id[11:1];
  assign func_rst_vf_active = r_act_id[0];
  assign overflow_err       = r_ovf;
  assign pending_cnt        = r_cnt;

endmodule
